adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined successor to the single-register adder: a WIDTH-bit adder/subtractor with a running accumulator, valid/ready flow control on both sides and a configurable pipeline depth. It sits between a stimulus/data source and any consumer that can stall. It is the arithmetic datapath block used for handshake-aware verification benches.

## Interface
- WIDTH, 8: operand width in bits (≥2).
- ACC_W, 16: result/accumulator width in bits (≥ WIDTH+1).
- STAGES, 2: pipeline register stages from accept to output (1..4).
- SAT, 0: 0 = accumulator wraps modulo 2^ACC_W; 1 = accumulator saturates at 2^ACC_W−1.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  source presents a, b, mode.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  output  1  result on sum/flag is valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  ACC_W  result.
- flag  output  1  carry/borrow/overflow indicator for the result.

## Operation
- Accept = in_valid && in_ready on a rising edge; the result is computed from a, b, mode and the accumulator at that edge and loaded into stage 0.
- ADD: sum = zero-extended a + b; flag = 0 (no overflow possible since ACC_W ≥ WIDTH+1).
- SUB: sum = a − b in ACC_W-bit two's complement (sign-extended); flag = 1 when b > a.
- ACC: acc_next = acc + zero-extended a; b ignored. Carry out of ACC_W bits sets flag = 1; SAT=0 → acc_next wraps; SAT=1 → acc_next = all-ones. sum = acc_next.
- CLR: acc_next = 0; sum = 0; flag = 0.
- The accumulator updates only on accept; ADD/SUB leave it unchanged.
- Pipeline: STAGES registers, each with its own valid bit. Stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready. out_valid = valid bit of the last stage; sum/flag = its data.
- in_ready = !valid[0] || stage 0 advancing (combinational from out_ready through the chain; full throughput of one result per cycle when out_ready is held high).
- Results leave in acceptance order; none dropped or duplicated.
- While out_valid && !out_ready, sum and flag hold stable.

## Timing
- Reset (rst high at a rising edge): all valid bits 0, accumulator 0, sum 0, flag 0, out_valid 0. in_ready = 1 during and after reset (combinationally, because the pipeline is empty).
- Reset mid-operation discards every in-flight result and the accumulator; an accept coinciding with rst high is discarded.
- Latency: accept at edge N → out_valid high after edge N+STAGES−1 (STAGES=1: visible right after the accepting edge), provided there is no stall.
- Capacity: STAGES entries. When all are full and out_ready=0, in_ready=0.
- Full pipeline with out_ready=1: accept and output occur in the same cycle; in_ready stays 1.
- Back-to-back ACC accepts see the accumulator value from the previous accept, with no hazard bubble.

## Test plan
- Reset then ADD: a=5,b=3 accepted at edge N, STAGES=2, out_ready=1 → out_valid at N+1, sum=8, flag=0; then a=255,b=1 → sum=256, flag=0.
- SUB: a=10,b=7 → sum=3, flag=0; a=3,b=5 → sum=16'hFFFE, flag=1.
- ACC wrap/saturate, ACC_W=9, WIDTH=8: CLR, then ACC a=255 twice → sums 255, 510 mod 512=510; a third ACC a=255 → SAT=0: sum=253, flag=1; SAT=1: sum=511, flag=1.
- Backpressure: stream 6 ADD pairs (i,i), i=1..6, with out_ready=0 for 5 cycles → in_ready drops after STAGES accepts and sum holds at 2. Release → outputs 2,4,6,8,10,12 in order, none lost.
- Throughput: in_valid and out_ready held high for 256 random ADD/SUB vectors → one result per cycle after the initial latency, every result matches the reference model.
- Mid-stream reset: 2 entries in flight plus acc=40, assert rst for 1 cycle → out_valid=0, sum=0; next ACC a=1 → sum=1.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor/accumulator with valid/ready on both sides.
// Each stage has its own valid bit, so empty slots fill while the consumer stalls.
`timescale 1ns/1ps

module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 16,
  parameter int STAGES = 2,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             flag
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  mode_e              w_mode;
  logic [ACC_W-1:0]   w_a_ext;
  logic [ACC_W-1:0]   w_b_ext;
  logic [ACC_W:0]     w_acc_wide;
  logic [ACC_W-1:0]   w_res;
  logic               w_res_flag;
  logic [ACC_W-1:0]   w_acc_next;
  logic [STAGES-1:0]  w_free;
  logic               w_accept;

  logic [STAGES-1:0]  r_valid;
  logic [ACC_W-1:0]   r_sum [STAGES];
  logic [STAGES-1:0]  r_flag;
  logic [ACC_W-1:0]   r_acc;

  assign w_mode     = mode_e'(mode);
  assign w_a_ext    = ACC_W'(a);
  assign w_b_ext    = ACC_W'(b);
  assign w_acc_wide = {1'b0, r_acc} + {1'b0, w_a_ext};

  // Stage k can take new data when any stage from k to the output has a hole,
  // or the output is being drained; written flat to avoid a bit-to-bit chain.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_free[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_valid[j]) w_free[k] = 1'b1;
      end
    end
  end

  assign in_ready = w_free[0];
  assign w_accept = in_valid && w_free[0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_res      = '0;
    w_res_flag = 1'b0;
    w_acc_next = r_acc;
    case (w_mode)
      MODE_ADD: w_res = w_a_ext + w_b_ext;
      MODE_SUB: begin
        w_res      = w_a_ext - w_b_ext;
        w_res_flag = (b > a);
      end
      MODE_ACC: begin
        w_res_flag = w_acc_wide[ACC_W];
        w_acc_next = (w_acc_wide[ACC_W] && SAT) ? '1 : w_acc_wide[ACC_W-1:0];
        w_res      = w_acc_next;
      end
      MODE_CLR: w_acc_next = '0;
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples
  // its predecessor's pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the valid bits because
      // sum/flag must read 0 after reset, not just out_valid.
      r_valid <= '0;
      r_flag  <= '0;
      r_acc   <= '0;
      for (int k = 0; k < STAGES; k++) r_sum[k] <= '0;
    end else begin
      if (w_accept) r_acc <= w_acc_next;
      if (w_free[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) begin
          r_sum[0]  <= w_res;
          r_flag[0] <= w_res_flag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_free[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_sum[k]  <= r_sum[k-1];
            r_flag[k] <= r_flag[k-1];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign flag      = r_flag[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three configurations share one stimulus stream, each
// checked against an arithmetic reference model through a per-instance scoreboard.
`timescale 1ns/1ps

module tb_adder_pipe;

  localparam int N_DUT = 3;

  // Instance 0: 8/16 bits, 2 stages, wrap. 1: 8/9, 1 stage, wrap. 2: 8/9, 3 stages, saturate.
  int acc_w_c [N_DUT] = '{16, 9, 9};
  bit sat_c   [N_DUT] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] mode = '0;

  logic        ir [N_DUT];
  logic        ov [N_DUT];
  logic        fv [N_DUT];
  logic [15:0] sv [N_DUT];
  logic [8:0]  sum1, sum2;

  int          n_cmp = 0;
  int          n_err = 0;
  longint      cyc = 0;
  logic [63:0] exp_q [N_DUT][$];
  longint      model_acc [N_DUT] = '{0, 0, 0};
  logic [63:0] last_out [N_DUT];
  int          n_out [N_DUT] = '{0, 0, 0};
  bit          stalled [N_DUT] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] held [N_DUT];
  bit          rand_phase = 1'b0;

  adder_pipe #(.WIDTH(8), .ACC_W(16), .STAGES(2), .SAT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .mode(mode), .out_valid(ov[0]), .out_ready(out_ready), .sum(sv[0]), .flag(fv[0])
  );
  adder_pipe #(.WIDTH(8), .ACC_W(9), .STAGES(1), .SAT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .mode(mode), .out_valid(ov[1]), .out_ready(out_ready), .sum(sum1), .flag(fv[1])
  );
  adder_pipe #(.WIDTH(8), .ACC_W(9), .STAGES(3), .SAT(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .mode(mode), .out_valid(ov[2]), .out_ready(out_ready), .sum(sum2), .flag(fv[2])
  );

  assign sv[1] = {7'b0, sum1};
  assign sv[2] = {7'b0, sum2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Result word: flag in bit 16, sum in the low bits.
  function automatic logic [63:0] model(input int d, input logic [1:0] m,
                                        input longint ai, input longint bi);
    longint mask, s, t;
    bit     f;
    mask = (longint'(1) << acc_w_c[d]) - 1;
    s = 0;
    f = 1'b0;
    case (m)
      2'd0: s = ai + bi;
      2'd1: begin
        s = (ai - bi) & mask;
        f = (bi > ai);
      end
      2'd2: begin
        t = model_acc[d] + ai;
        if (t > mask) begin
          f = 1'b1;
          s = sat_c[d] ? mask : (t & mask);
        end else begin
          s = t;
        end
        model_acc[d] = s;
      end
      default: model_acc[d] = 0;
    endcase
    return 64'((longint'(f) << 16) | s);
  endfunction

  function automatic logic [63:0] obs(input int d);
    return {47'b0, fv[d], sv[d]};
  endfunction

  // Scoreboard: sampled mid-cycle, describing what the next rising edge will do.
  always @(negedge clk) begin
    for (int d = 0; d < N_DUT; d++) begin
      if (stalled[d]) begin
        check($sformatf("hold_valid%0d", d), ov[d], 1);
        check($sformatf("hold_data%0d", d), obs(d), held[d]);
      end
      if (rst) begin
        exp_q[d].delete();
        model_acc[d] = 0;
        stalled[d] = 1'b0;
      end else begin
        if (ov[d] && out_ready) begin
          check($sformatf("sb_nonempty%0d", d), exp_q[d].size() != 0, 1);
          if (exp_q[d].size() != 0)
            check($sformatf("sb_result%0d", d), obs(d), exp_q[d].pop_front());
          last_out[d] = obs(d);
          n_out[d]++;
        end
        if (in_valid && ir[d]) exp_q[d].push_back(model(d, mode, {56'b0, a}, {56'b0, b}));
        stalled[d] = ov[d] && !out_ready;
        held[d] = obs(d);
      end
    end
  end

  // Presents one operation and holds it until instance 0 takes it.
  task automatic send(input logic [1:0] m, input logic [7:0] ai, input logic [7:0] bi);
    int n = 0;
    mode = m;
    a = ai;
    b = bi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ir[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (rand_phase && n >= 2) out_ready = 1'b1;
      @(negedge clk);
    end
    check("send_stall", n >= 200, 0);
    if (n < 200) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    longint t0, t1;
    int     k0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", ir[0], 1);
    check("rst_out_valid", ov[0], 0);
    check("rst_sum", sv[0], 0);
    check("rst_flag", fv[0], 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Latency for 1, 2 and 3 stages.
    mode = 2'd0; a = 8'd5; b = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat1_valid", ov[1], 1);
    check("lat1_sum", sv[1], 8);
    check("lat2_early", ov[0], 0);
    @(posedge clk);
    #1;
    check("lat2_valid", ov[0], 1);
    check("lat2_sum", sv[0], 8);
    check("lat2_flag", fv[0], 0);
    check("lat3_early", ov[2], 0);
    @(posedge clk);
    #1;
    check("lat3_valid", ov[2], 1);
    idle(3);

    send(2'd0, 8'd255, 8'd1); idle(4);
    check("add_255_1", last_out[0], 64'd256);
    send(2'd1, 8'd10, 8'd7); idle(4);
    check("sub_10_7", last_out[0], 64'd3);
    send(2'd1, 8'd3, 8'd5); idle(4);
    check("sub_3_5", last_out[0], 64'h1_FFFE);

    // Accumulator wrap (9-bit, wrap) and saturate (9-bit, SAT).
    send(2'd3, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) send(2'd2, 8'd255, 8'($urandom));
    idle(5);
    check("acc_wide", last_out[0], 64'd765);
    check("acc_wrap", last_out[1], 64'h1_00FD);
    check("acc_sat", last_out[2], 64'h1_01FF);

    // Backpressure: six ADD (i,i) with the consumer stalled for five cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(2'd0, 8'(i), 8'(i));
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (ov[0]) check("bp_sum_hold", sv[0], 2);
        end
        @(negedge clk);
        check("bp_in_ready", ir[0], 0);
        check("bp_out_valid", ov[0], 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_last", last_out[0], 64'd12);

    // Throughput: one accept per cycle with out_ready held high.
    t0 = cyc;
    k0 = n_out[0];
    for (int i = 0; i < 256; i++) send(2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    t1 = cyc;
    check("thru_cycles", 64'(t1 - t0), 256);
    idle(5);
    check("thru_count", n_out[0] - k0, 256);

    // Mid-stream reset with two entries in flight and acc = 40.
    send(2'd3, 8'd0, 8'd0);
    send(2'd2, 8'd40, 8'd0);
    idle(4);
    check("acc_40", last_out[0], 64'd40);
    out_ready = 1'b0;
    send(2'd0, 8'd1, 8'd1);
    send(2'd0, 8'd2, 8'd2);
    check("full_in_ready", ir[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_out_valid", ov[0], 0);
    check("mrst_sum", sv[0], 0);
    check("mrst_in_ready", ir[0], 1);
    out_ready = 1'b1;
    send(2'd2, 8'd1, 8'd0);
    idle(3);
    check("mrst_acc", last_out[0], 64'd1);

    // Mixed random traffic with random consumer stalls and source gaps.
    rand_phase = 1'b1;
    repeat (300) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(2'($urandom), 8'($urandom), 8'($urandom));
    end
    rand_phase = 1'b0;
    out_ready = 1'b1;
    idle(10);
    for (int d = 0; d < N_DUT; d++) check($sformatf("drain%0d", d), exp_q[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
